// File: rtl/spi_cfg_master_if.sv
// Bundles the configuration-sequencer handshake and the 3-wire SPI pad
// signals of spi_cfg_master. ADDR_W/DATA_W must match the master's.
interface spi_cfg_master_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              cs_n;
  logic              sclk;
  logic              sdio_o;
  logic              sdio_oe;
  logic              sdio_i;

  modport master (
    input  start, rw, addr, wdata, sdio_i,
    output ready, busy, done, rdata, cs_n, sclk, sdio_o, sdio_oe
  );

  modport slave (
    output start, rw, addr, wdata, sdio_i,
    input  ready, busy, done, rdata, cs_n, sclk, sdio_o, sdio_oe
  );
endinterface

// File: rtl/spi_cfg_master.sv
// 3-wire SPI configuration master: frame {rw, 2'b00, addr, data} sent MSB
// first in SPI mode 0, programmable SCLK divider and cs_n setup/hold, with
// half-duplex read-back of the data field over the shared SDIO line.
module spi_cfg_master #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input logic             clk,
  input logic             rst,
  spi_cfg_master_if.master bus
);

  localparam int HDR_W   = 3 + ADDR_W;
  localparam int FRAME_W = HDR_W + DATA_W;
  localparam int PERIOD  = 2 * CLK_DIV;
  localparam int CNT_MAX = (CS_SETUP > PERIOD) ?
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD) :
                           ((PERIOD > CS_HOLD) ? PERIOD : CS_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF        = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] DATA_FIRST  = BIT_W'(HDR_W);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [BIT_W-1:0]   bit_idx, bit_d;
  logic [FRAME_W-1:0] sreg, sreg_d;
  logic               rw_q, rw_d;
  logic [DATA_W-1:0]  rx;

  // Next output values (p0) and their registered copies (p1)
  logic              cs_n_p0, sclk_p0, sdio_p0, oe_p0, done_p0;
  logic              sample_p0, load_rdata_p0;
  logic              cs_n_p1, sclk_p1, sdio_p1, oe_p1, done_p1;
  logic [DATA_W-1:0] rdata_p1;

  // State register: FSM state and its phase/bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
    end
  end

  // Next state: phase sequencing, request capture and frame shifting
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    sreg_d  = sreg;
    rw_d    = rw_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          rw_d    = bus.rw;
          // Read frames send zeros in the data field while the pad is released
          sreg_d  = {bus.rw, 2'b00, bus.addr, (bus.rw ? {DATA_W{1'b0}} : bus.wdata)};
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt == PERIOD_LAST) begin
          cnt_d = '0;
          if (bit_idx == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            bit_d  = bit_idx + 1'b1;
            sreg_d = {sreg[FRAME_W-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every pad output comes from a flop
  always_comb begin
    cs_n_p0       = (state_d == S_IDLE);
    sclk_p0       = (state_d == S_SHIFT) && (cnt_d >= HALF);
    oe_p0         = !(rw_d && (state_d == S_SHIFT) && (bit_d >= DATA_FIRST));
    sdio_p0       = oe_p0 && ((state_d == S_SETUP) || (state_d == S_SHIFT)) ?
                    sreg_d[FRAME_W-1] : 1'b0;
    done_p0       = (state == S_HOLD) && (state_d == S_IDLE);
    sample_p0     = (state_d == S_SHIFT) && (cnt_d == HALF);
    load_rdata_p0 = rw_q && (state == S_SHIFT) && (state_d == S_HOLD);
  end

  // Frame data path: shift register, latched direction, read-back shifter
  always_ff @(posedge clk) begin
    sreg <= sreg_d;
    rw_q <= rw_d;
    if (sample_p0) begin
      rx <= (rx << 1) | DATA_W'(bus.sdio_i);
    end
  end

  // Registered outputs (p0 -> p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_p1  <= 1'b1;
      sclk_p1  <= 1'b0;
      sdio_p1  <= 1'b0;
      oe_p1    <= 1'b1;
      done_p1  <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      cs_n_p1 <= cs_n_p0;
      sclk_p1 <= sclk_p0;
      sdio_p1 <= sdio_p0;
      oe_p1   <= oe_p0;
      done_p1 <= done_p0;
      if (load_rdata_p0) begin
        rdata_p1 <= rx;
      end
    end
  end

  assign bus.cs_n    = cs_n_p1;
  assign bus.sclk    = sclk_p1;
  assign bus.sdio_o  = sdio_p1;
  assign bus.sdio_oe = oe_p1;
  assign bus.done    = done_p1;
  assign bus.rdata   = rdata_p1;
  assign bus.busy    = (state != S_IDLE);
  assign bus.ready   = (state == S_IDLE);

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: three configurations (defaults; CLK_DIV=1 with
// 2-cycle cs setup/hold; ADDR_W=7/DATA_W=16) watched by a pin-level device
// model, with expected frames queued at launch and checked at done.
module tb_spi_cfg_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cfg_master_if #(.ADDR_W(13), .DATA_W(8))  if0 ();
  spi_cfg_master_if #(.ADDR_W(13), .DATA_W(8))  if1 ();
  spi_cfg_master_if #(.ADDR_W(7),  .DATA_W(16)) if2 ();

  spi_cfg_master #(.ADDR_W(13), .DATA_W(8), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  spi_cfg_master #(.ADDR_W(13), .DATA_W(8), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  spi_cfg_master #(.ADDR_W(7), .DATA_W(16), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    int          inst;
    bit          rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dev;
    logic [31:0] cap;
    logic [15:0] rdata;
    int          cs_len;
    int          oe_low;
    int          rises;
  } vec_t;

  vec_t tbl [8];
  vec_t sb [$];

  int errors = 0;
  int checks = 0;

  // Pin views gathered into arrays so one monitor serves all instances
  logic        cs_n_a [3];
  logic        sclk_a [3];
  logic        sdo_a  [3];
  logic        oe_a   [3];
  logic        done_a [3];
  logic        ready_a[3];
  logic [15:0] rdata_a[3];
  assign cs_n_a[0] = if0.cs_n;    assign cs_n_a[1] = if1.cs_n;    assign cs_n_a[2] = if2.cs_n;
  assign sclk_a[0] = if0.sclk;    assign sclk_a[1] = if1.sclk;    assign sclk_a[2] = if2.sclk;
  assign sdo_a[0]  = if0.sdio_o;  assign sdo_a[1]  = if1.sdio_o;  assign sdo_a[2]  = if2.sdio_o;
  assign oe_a[0]   = if0.sdio_oe; assign oe_a[1]   = if1.sdio_oe; assign oe_a[2]   = if2.sdio_oe;
  assign done_a[0] = if0.done;    assign done_a[1] = if1.done;    assign done_a[2] = if2.done;
  assign ready_a[0] = if0.ready;  assign ready_a[1] = if1.ready;  assign ready_a[2] = if2.ready;
  assign rdata_a[0] = {8'h00, if0.rdata};
  assign rdata_a[1] = {8'h00, if1.rdata};
  assign rdata_a[2] = if2.rdata;

  // Device model state
  logic [31:0] cap      [3];
  int          nrise    [3];
  int          rise_tot [3];
  int          cur_cs   [3];
  int          last_cs  [3];
  int          cur_gap  [3];
  int          last_gap [3];
  int          oe_low   [3];
  int          frames   [3];
  int          done_tot [3];
  int          idle_bad [3];
  logic        cs_prev  [3];
  logic        sclk_prev[3];
  logic [15:0] dev_word [3];
  logic        s_in     [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; nrise[i] = 0; rise_tot[i] = 0; cur_cs[i] = 0; last_cs[i] = 0;
      cur_gap[i] = 0; last_gap[i] = 0; oe_low[i] = 0; frames[i] = 0; done_tot[i] = 0;
      idle_bad[i] = 0; cs_prev[i] = 1'b1; sclk_prev[i] = 1'b0;
    end
  end

  // Device capture: sdio_o on every sclk rise, frame/gap lengths per cs_n window
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!cs_n_a[i]) begin
        if (cs_prev[i]) begin
          cur_cs[i]   <= 1;
          nrise[i]    <= 0;
          cap[i]      <= '0;
          oe_low[i]   <= oe_a[i] ? 0 : 1;
          frames[i]   <= frames[i] + 1;
          last_gap[i] <= cur_gap[i];
        end else begin
          cur_cs[i] <= cur_cs[i] + 1;
          if (!oe_a[i]) oe_low[i] <= oe_low[i] + 1;
        end
      end else begin
        if (!cs_prev[i]) begin
          last_cs[i] <= cur_cs[i];
          cur_gap[i] <= 1;
        end else begin
          cur_gap[i] <= cur_gap[i] + 1;
        end
        if (sclk_a[i]) idle_bad[i] <= idle_bad[i] + 1;
      end
      if (sclk_a[i] && !sclk_prev[i]) begin
        cap[i]      <= {cap[i][30:0], sdo_a[i]};
        nrise[i]    <= nrise[i] + 1;
        rise_tot[i] <= rise_tot[i] + 1;
      end
      if (done_a[i]) done_tot[i] <= done_tot[i] + 1;
      cs_prev[i]   <= cs_n_a[i];
      sclk_prev[i] <= sclk_a[i];
    end
  end

  // Device read-back drive: data bit for the upcoming sclk rise
  always_comb begin
    s_in[0] = 1'b0;
    s_in[1] = 1'b0;
    s_in[2] = 1'b0;
    if (nrise[0] >= 16 && nrise[0] < 24) s_in[0] = dev_word[0][4'(23 - nrise[0])];
    if (nrise[1] >= 16 && nrise[1] < 24) s_in[1] = dev_word[1][4'(23 - nrise[1])];
    if (nrise[2] >= 10 && nrise[2] < 26) s_in[2] = dev_word[2][4'(25 - nrise[2])];
  end
  assign if0.sdio_i = s_in[0];
  assign if1.sdio_i = s_in[1];
  assign if2.sdio_i = s_in[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int inst, input bit s, input bit rw,
                         input logic [15:0] a, input logic [15:0] w);
    case (inst)
      0: begin if0.start = s; if0.rw = rw; if0.addr = a[12:0]; if0.wdata = w[7:0]; end
      1: begin if1.start = s; if1.rw = rw; if1.addr = a[12:0]; if1.wdata = w[7:0]; end
      default: begin if2.start = s; if2.rw = rw; if2.addr = a[6:0]; if2.wdata = w; end
    endcase
  endtask

  // One-cycle start pulse; fields are scrambled afterwards to show they are not re-sampled
  task automatic launch(input int inst, input bit rw, input logic [15:0] a, input logic [15:0] w);
    @(negedge clk);
    set_req(inst, 1'b1, rw, a, w);
    @(negedge clk);
    set_req(inst, 1'b0, ~rw, ~a, ~w);
  endtask

  task automatic wait_done(input int inst, input int budget, output bit ok, output int rdy_hi);
    ok = 1'b0;
    rdy_hi = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_a[inst]) begin
        ok = 1'b1;
        break;
      end
      if (ready_a[inst]) rdy_hi++;
    end
  endtask

  task automatic check_frame(input int inst, input bit ok, input int rdy_hi);
    vec_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: actual=empty required=entry");
      return;
    end
    e = sb.pop_front();
    chk("timeout",  32'(ok),         32'd1);
    chk("capture",  cap[inst],       e.cap);
    chk("rdata",    32'(rdata_a[inst]), 32'(e.rdata));
    chk("cs_len",   last_cs[inst],   e.cs_len);
    chk("oe_low",   oe_low[inst],    e.oe_low);
    chk("rises",    nrise[inst],     e.rises);
    chk("ready_hi", rdy_hi,          0);
  endtask

  initial begin
    bit ok;
    int rh, d0, f0, rt;
    vec_t t;

    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int rh, d0, f0, rt;
    vec_t t;

    //        inst rw  addr      wdata     dev       capture       rdata     cs   oe  rises
    tbl[0] = '{0, 1'b0, 16'h0123, 16'h00A5, 16'h0000, 32'h000123A5, 16'h0000, 98,  0,  24};
    tbl[1] = '{0, 1'b1, 16'h0005, 16'h00FF, 16'h003C, 32'h00800500, 16'h003C, 98,  32, 24};
    tbl[2] = '{0, 1'b0, 16'h1FFF, 16'h0000, 16'h00FF, 32'h001FFF00, 16'h003C, 98,  0,  24};
    tbl[3] = '{0, 1'b1, 16'h0AAA, 16'h0055, 16'h00C3, 32'h008AAA00, 16'h00C3, 98,  32, 24};
    tbl[4] = '{2, 1'b1, 16'h0005, 16'h0000, 16'hBEEF, 32'h02050000, 16'hBEEF, 106, 64, 26};
    tbl[5] = '{2, 1'b0, 16'h007F, 16'h1234, 16'hFFFF, 32'h007F1234, 16'hBEEF, 106, 0,  26};
    tbl[6] = '{1, 1'b0, 16'h0001, 16'h0011, 16'h0000, 32'h00000111, 16'h0000, 52,  0,  24};
    tbl[7] = '{1, 1'b1, 16'h1000, 16'h0000, 16'h0081, 32'h00900000, 16'h0081, 52,  16, 24};

    for (int i = 0; i < 3; i++) begin
      dev_word[i] = '0;
      set_req(i, 1'b0, 1'b0, 16'h0, 16'h0);
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",  32'(if0.cs_n),    32'd1);
    chk("rst_sclk",  32'(if0.sclk),    32'd0);
    chk("rst_sdio",  32'(if0.sdio_o),  32'd0);
    chk("rst_oe",    32'(if0.sdio_oe), 32'd1);
    chk("rst_busy",  32'(if0.busy),    32'd0);
    chk("rst_ready", 32'(if0.ready),   32'd1);
    chk("rst_done",  32'(if0.done),    32'd0);
    chk("rst_rdata", 32'(if0.rdata),   32'd0);
    chk("rst_rdata2", 32'(if2.rdata),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single frames
    for (int v = 0; v < 8; v++) begin
      t = tbl[v];
      dev_word[t.inst] = t.dev;
      d0 = done_tot[t.inst];
      sb.push_back(t);
      launch(t.inst, t.rw, t.addr, t.wdata);
      wait_done(t.inst, 400, ok, rh);
      check_frame(t.inst, ok, rh);
      repeat (2) @(negedge clk);
      #1;
      chk("done_pulses", done_tot[t.inst] - d0, 1);
    end

    // Busy rejection: a start with addr 0x1FFF mid-frame is dropped
    f0 = frames[0];
    sb.push_back('{0, 1'b0, 16'h0123, 16'h005A, 16'h0000, 32'h0001235A, 16'h00C3, 98, 0, 24});
    launch(0, 1'b0, 16'h0123, 16'h005A);
    repeat (20) @(negedge clk);
    chk("busy_ready", 32'(if0.ready), 32'd0);
    chk("busy_busy",  32'(if0.busy),  32'd1);
    set_req(0, 1'b1, 1'b0, 16'h1FFF, 16'h00FF);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_done(0, 400, ok, rh);
    check_frame(0, ok, rh);
    repeat (150) @(negedge clk);
    #1;
    chk("rejected_frames", frames[0] - f0, 1);

    // Back-to-back with start held high across the done cycle
    d0 = done_tot[1];
    sb.push_back('{1, 1'b0, 16'h0001, 16'h0011, 16'h0000, 32'h00000111, 16'h0081, 52, 0, 24});
    sb.push_back('{1, 1'b0, 16'h0002, 16'h0022, 16'h0000, 32'h00000222, 16'h0081, 52, 0, 24});
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 16'h0001, 16'h0011);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 16'h0002, 16'h0022);
    wait_done(1, 200, ok, rh);
    check_frame(1, ok, rh);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_done(1, 200, ok, rh);
    check_frame(1, ok, rh);
    chk("b2b_gap", last_gap[1], 1);
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_done_pulses", done_tot[1] - d0, 2);

    // Reset mid-SHIFT of a write
    launch(0, 1'b0, 16'h0155, 16'h0077);
    repeat (40) @(negedge clk);
    d0 = done_tot[0];
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cs_n",  32'(if0.cs_n),    32'd1);
    chk("mid_rst_sclk",  32'(if0.sclk),    32'd0);
    chk("mid_rst_sdio",  32'(if0.sdio_o),  32'd0);
    chk("mid_rst_oe",    32'(if0.sdio_oe), 32'd1);
    chk("mid_rst_busy",  32'(if0.busy),    32'd0);
    chk("mid_rst_ready", 32'(if0.ready),   32'd1);
    chk("mid_rst_done",  32'(if0.done),    32'd0);
    chk("mid_rst_rdata", 32'(if0.rdata),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    rt = rise_tot[0];
    repeat (150) @(negedge clk);
    #1;
    chk("mid_rst_no_sclk", rise_tot[0] - rt, 0);
    chk("mid_rst_no_done", done_tot[0] - d0, 0);

    // Block usable again after reset; rdata cleared by reset
    t = tbl[0];
    sb.push_back(t);
    launch(0, t.rw, t.addr, t.wdata);
    wait_done(0, 400, ok, rh);
    check_frame(0, ok, rh);

    for (int i = 0; i < 3; i++) chk("sclk_idle_low", idle_bad[i], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

Parametrised 3-wire SPI configuration master for register-mapped converter and PLL devices. Generalises the single-write configuration sender: it adds configurable address and data widths, a programmable SCLK divider, programmable chip-select setup and hold, and half-duplex read-back over a shared SDIO line. It sits between the board-level configuration sequencer (start/ready handshake) and the device pins.

## Interface
- ADDR_W, 13: register address width (≥1).
- DATA_W, 8: register data width (≥1).
- CLK_DIV, 2: SCLK half-period in clk cycles (≥1).
- CS_SETUP, 1: clk cycles from cs_n fall to first SCLK low phase (≥1).
- CS_HOLD, 1: clk cycles from last SCLK high phase to cs_n rise (≥1).
- Derived: FRAME_W = 3 + ADDR_W + DATA_W (default 24).

Ports:
- clk  in  1  system clock. One clock.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a frame; accepted only when ready=1.
- rw  in  1  1 = read, 0 = write. Sampled with start.
- addr  in  ADDR_W  register address. Sampled with start.
- wdata  in  DATA_W  write data. Sampled with start; ignored for reads.
- ready  out  1  block idle; equals !busy.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.
- rdata  out  DATA_W  last read word.
- cs_n  out  1  chip select, active-low.
- sclk  out  1  serial clock, idle low (mode 0).
- sdio_o  out  1  serial data out.
- sdio_oe  out  1  1 = master drives the SDIO pad.
- sdio_i  in  1  serial data in from the pad.

## Operation
- Frame, sent MSB first: {rw, 2'b00 (single-word), addr, data field}. The data field is wdata for writes and DATA_W read bits for reads.
- FSM states: IDLE → SETUP → SHIFT → HOLD → IDLE.
  - IDLE: if start=1, latch {rw, addr, wdata} into the shift register and go to SETUP.
  - SETUP: stay CS_SETUP cycles; sdio_o = frame MSB.
  - SHIFT: FRAME_W bit periods of 2·CLK_DIV cycles each.
  - HOLD: stay CS_HOLD cycles, then go to IDLE.
- Each bit period:
  - sdio_o holds the bit for the whole period.
  - sclk is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
  - The device samples on sclk rising.
- Read frames:
  - sdio_oe=0 for the final DATA_W bit periods; sdio_o=0 while not driving.
  - sdio_i is sampled on the clk edge that drives sclk 0→1 and shifted in MSB first.
  - rdata is updated on the edge that enters HOLD.
- Write frames leave rdata unchanged.
- start while busy=1 is ignored, with no queuing.
- Inputs are sampled only on the accept edge. Changes to them mid-frame have no effect.

## Timing
- Reset values (asserted on the edge after rst=1, including mid-frame): state IDLE, cs_n=1, sclk=0, sdio_o=0, sdio_oe=1, busy=0, ready=1, done=0, rdata=0. No partial rdata update.
- Accept edge E0, where start=1 in IDLE: from E0, cs_n=0 and busy=1.
- cs_n low for exactly CS_SETUP + 2·CLK_DIV·FRAME_W + CS_HOLD cycles (default 98).
- On the edge leaving HOLD: cs_n=1, busy=0, done=1 for exactly one cycle.
- A start in the done cycle is accepted, so the minimum cs_n high gap between frames is 1 cycle.
- sclk is low throughout SETUP, HOLD and IDLE. Each frame has exactly FRAME_W rising edges.
- sdio_oe falls on the edge that begins the first data-bit period and rises on the edge entering HOLD.
- All outputs are registered; there are no combinational paths from inputs to outputs except ready/busy, which reflect state.

## Test plan
- Reset: assert rst mid-SHIFT of a write. On the next edge, all outputs equal their reset values, no done pulse, and sclk has no further edges.
- Write, defaults: addr=0x0123, wdata=0xA5, rw=0. The device model captures 0x0123A5 on 24 sclk rising edges, cs_n is low for 98 cycles, done fires once, and sdio_oe stays 1 throughout.
- Read, defaults: addr=0x0005, rw=1, with the device driving 0x3C in the data phase. Captured header is 0x8005, sdio_oe=0 for exactly 32 cycles, and rdata=0x3C when done fires.
- Busy rejection: pulse start with addr=0x1FFF during a frame. That request is never sent and ready stays 0 until done.
- Back-to-back, CLK_DIV=1, CS_SETUP=CS_HOLD=2, start held high for two writes (0x0001/0x11, 0x0002/0x22). Result: two frames, each with cs_n low for 52 cycles, separated by one cs_n-high cycle, and two done pulses.
- Width generality: ADDR_W=7, DATA_W=16, read with the device driving 0xBEEF. Result: 26 sclk rising edges and rdata=0xBEEF.
